data_sram_response: RTL and testbench
=====================================

Name: data_sram_response

Overview:
- MEM-stage consumer of the data SRAM-like bus. It sits directly downstream of the EX-stage request generator.
- Tracks the request that the instruction now in MEM issued, waits for data_ok and stalls MEM until the response arrives.
- Holds response data while WB cannot accept it, extracts and sign/zero-extends load data, and discards responses that belong to flushed instructions.

Parameters:
- DISCARD_MAX, 3, maximum number of flushed in-flight responses that can be tracked for discard; the counter width is clog2(DISCARD_MAX+1).

Ports:
- clk  input  1  clock.
- resetn  input  1  synchronous reset, active-low.
- data_sram_data_ok  input  1  response handshake; one pulse per accepted request, in order.
- data_sram_rdata  input  32  read data, valid when data_ok=1.
- req_accepted_EX  input  1  data_sram_req & data_sram_addr_ok in EX this cycle.
- EX_MEM_advance  input  1  the EX instruction moves into MEM at this clock edge.
- MEM_WB_advance  input  1  the MEM instruction moves into WB at this clock edge.
- flush  input  1  exception/eret; kills the instruction in MEM and all younger instructions.
- mem_ren_MEM  input  1  the MEM instruction is a load.
- mem_w_MEM, mem_h_MEM, mem_b_MEM, mem_hu_MEM, mem_bu_MEM, mem_wl_MEM, mem_wr_MEM  input  1 each  load type.
- byte_offset_MEM  input  2  physical address [1:0] of the MEM access.
- rt_old_MEM  input  32  old rt value used for the lwl/lwr merge.
- load_data_MEM  output  32  extracted load result.
- MEM_reg_stall_mem_not_ready  output  1  the MEM stage must hold.
- resp_busy  output  1  the discard counter is nonzero; the EX stage must not issue new requests.

Behaviour:
- Per-MEM-slot FSM with states EMPTY, WAIT, HELD. Reset puts it in EMPTY, clears the discard counter and clears the data buffer. All outputs are 0 after reset.
- EMPTY -> WAIT: on EX_MEM_advance & req_accepted_EX & ~flush.
- A request whose data_ok arrives in the same cycle it enters MEM is impossible; data_ok is at least one cycle after addr_ok.
- WAIT, data_ok=1, no discard pending: capture rdata into the buffer.
  - If MEM_WB_advance is 1 in the same cycle, go to EMPTY (or to WAIT if a new request enters).
  - Otherwise go to HELD.
- HELD -> EMPTY/WAIT: on MEM_WB_advance, depending on a new entering request.
- MEM_reg_stall_mem_not_ready = (state==WAIT) & ~(data_ok & discard==0). It is 0 in EMPTY and HELD. It is combinational, so it has zero latency.
- load_data_MEM uses the live rdata in the data_ok cycle and the buffer in HELD.
- Data ordering: while the discard counter is nonzero, every data_ok decrements it and the data is dropped. The WAIT slot only consumes data_ok once the counter is 0.
- Flush in WAIT: discard += 1; slot goes to EMPTY.
  - If req_accepted_EX & EX_MEM_advance occur in the same cycle, add a further 1, for +2 total.
  - If data_ok arrives in the same flush cycle, it first satisfies the accounting: the net change is computed as (+killed outstanding) − (data_ok & counter-or-WAIT consuming).
- Flush in HELD: data is dropped; slot goes to EMPTY; the counter is unchanged.
- The counter saturates at DISCARD_MAX. resp_busy=1 while the counter is nonzero, which guarantees no overflow.
- Extraction by byte offset o:
  - lb/lbu: byte o, sign/zero extended.
  - lh/lhu: halfword o[1], sign/zero extended.
  - lw: the word.
- store-only instructions (mem_ren_MEM=0) still pass through WAIT, but load_data_MEM is don't-care.
- resetn low mid-transaction clears all state. The bus is reset together with the core, so no stale data_ok follows.

Optional Feature:
- LWLR_EN defined: lwl/lwr are supported, merged little-endian.
  - lwl with offset o writes the high (o+1) bytes from rdata bytes o..0, keeping the low bytes of rt_old_MEM.
  - lwr with offset o writes the low (4−o) bytes from rdata bytes 3..o, keeping the high bytes of rt_old_MEM.
- LWLR_EN undefined: mem_wl_MEM and mem_wr_MEM are ignored, lwl/lwr return the full word as lw, and the merge logic is absent.

Test Plan:
- lb, offset 2: a load enters with req accepted; data_ok arrives 3 cycles later with rdata=0x12_80_34_56 and MEM_WB_advance=1 -> stall=1 for 3 cycles, then load_data=0xFFFFFF80; state ends EMPTY.
- lhu, offset 2: data_ok arrives while MEM_WB_advance=0, rdata=0xBEEF0000 -> state HELD; load_data stays 0x0000BEEF for 2 stalled WB cycles; changing rdata on the bus has no effect.
- Flush in WAIT plus a new request: flush in WAIT, then a new load issues 1 cycle later -> discard=1 and resp_busy=1. The first data_ok is dropped; the second data_ok (0xCAFEF00D, lw) gives load_data=0xCAFEF00D.
- Double discard: flush in the same cycle as a new request entering MEM -> discard=2; two data_ok pulses are dropped; the counter returns to 0 and resp_busy deasserts.
- Reset mid-WAIT: resetn=0 for 1 cycle while in WAIT with discard=1 -> state EMPTY, discard=0, all outputs 0 on the next cycle.
- LWLR_EN: lwl with offset 1, rdata=0xAABBCCDD, rt_old=0x11223344 -> 0xCCDD3344. lwr with offset 1 -> 0x11AABBCC.

Source files
------------

// File: rtl/data_sram_response.sv
// MEM-stage consumer of data SRAM responses: waits for data_ok, buffers data while WB stalls,
// extracts load results and drops responses of flushed instructions. LWLR_EN enables lwl/lwr merging.
module data_sram_response #(
  parameter int unsigned DISCARD_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        req_accepted_EX,
  input  logic        EX_MEM_advance,
  input  logic        MEM_WB_advance,
  input  logic        flush,
  input  logic        mem_ren_MEM,
  input  logic        mem_w_MEM,
  input  logic        mem_h_MEM,
  input  logic        mem_b_MEM,
  input  logic        mem_hu_MEM,
  input  logic        mem_bu_MEM,
  input  logic        mem_wl_MEM,
  input  logic        mem_wr_MEM,
  input  logic [1:0]  byte_offset_MEM,
  input  logic [31:0] rt_old_MEM,
  output logic [31:0] load_data_MEM,
  output logic        MEM_reg_stall_mem_not_ready,
  output logic        resp_busy
);

  localparam int unsigned CW = $clog2(DISCARD_MAX + 1);
  localparam logic [CW+1:0] CNT_MAX = (CW+2)'(DISCARD_MAX);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] discard;
  logic [31:0]   buffer;

  logic          new_req;
  logic          enter;
  logic          cnt_zero;
  logic          in_wait;
  logic          take;
  logic          dec;
  logic [1:0]    inc;
  logic [CW+1:0] cnt_sum;
  logic [CW-1:0] discard_next;
  logic [31:0]   word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_inputs;

  assign new_req  = EX_MEM_advance & req_accepted_EX;
  assign enter    = new_req & ~flush;
  assign cnt_zero = (discard == '0);
  assign in_wait  = (state == WAIT);
  assign take     = in_wait & data_sram_data_ok & cnt_zero;

  // A flush orphans the waiting request and any request entering behind it; a data_ok
  // in the same cycle retires one orphan (or the waiting request itself) immediately.
  assign inc = flush ? ({1'b0, in_wait} + {1'b0, new_req}) : 2'd0;
  assign dec = data_sram_data_ok & (~cnt_zero | (in_wait & flush));

  always_comb begin
    cnt_sum      = (CW+2)'(discard) + (CW+2)'(inc) - (CW+2)'(dec);
    discard_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CW-1:0] : cnt_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= EMPTY;
      discard <= '0;
      buffer  <= '0;
    end else begin
      discard <= discard_next;
      if (take && !flush) begin
        buffer <= data_sram_rdata;
      end
      case (state)
        EMPTY: begin
          if (enter) state <= WAIT;
        end
        WAIT: begin
          if (flush) begin
            state <= EMPTY;
          end else if (take) begin
            if (MEM_WB_advance) state <= enter ? WAIT : EMPTY;
            else                state <= HELD;
          end
        end
        HELD: begin
          if (flush) begin
            state <= EMPTY;
          end else if (MEM_WB_advance) begin
            state <= enter ? WAIT : EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign MEM_reg_stall_mem_not_ready = in_wait & ~(data_sram_data_ok & cnt_zero);
  assign resp_busy                   = ~cnt_zero;

  always_comb begin
    word = take ? data_sram_rdata : buffer;
    case (byte_offset_MEM)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel      = byte_offset_MEM[1] ? word[31:16] : word[15:0];
    load_data_MEM = word;
    if (mem_b_MEM)       load_data_MEM = {{24{byte_sel[7]}}, byte_sel};
    else if (mem_bu_MEM) load_data_MEM = {24'h0, byte_sel};
    else if (mem_h_MEM)  load_data_MEM = {{16{half_sel[15]}}, half_sel};
    else if (mem_hu_MEM) load_data_MEM = {16'h0, half_sel};
`ifdef LWLR_EN
    else if (mem_wl_MEM) begin
      case (byte_offset_MEM)
        2'd0:    load_data_MEM = {word[7:0],  rt_old_MEM[23:0]};
        2'd1:    load_data_MEM = {word[15:0], rt_old_MEM[15:0]};
        2'd2:    load_data_MEM = {word[23:0], rt_old_MEM[7:0]};
        default: load_data_MEM = word;
      endcase
    end else if (mem_wr_MEM) begin
      case (byte_offset_MEM)
        2'd0:    load_data_MEM = word;
        2'd1:    load_data_MEM = {rt_old_MEM[31:24], word[31:8]};
        2'd2:    load_data_MEM = {rt_old_MEM[31:16], word[31:16]};
        default: load_data_MEM = {rt_old_MEM[31:8],  word[31:24]};
      endcase
    end
`endif
  end

`ifdef LWLR_EN
  assign unused_inputs = ^{mem_ren_MEM, mem_w_MEM};
`else
  assign unused_inputs = ^{mem_ren_MEM, mem_w_MEM, mem_wl_MEM, mem_wr_MEM, rt_old_MEM};
`endif

endmodule

// File: tb/tb_data_sram_response.sv
// Scoreboard bench for data_sram_response: a transaction-level model of in-flight requests
// predicts stall, busy and load results; a negedge monitor compares them against the DUT.
module tb_data_sram_response;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        req_accepted_EX;
  logic        EX_MEM_advance;
  logic        MEM_WB_advance;
  logic        flush;
  logic        mem_ren_MEM, mem_w_MEM, mem_h_MEM, mem_b_MEM, mem_hu_MEM, mem_bu_MEM;
  logic        mem_wl_MEM, mem_wr_MEM;
  logic [1:0]  byte_offset_MEM;
  logic [31:0] rt_old_MEM;
  logic [31:0] load_data_MEM;
  logic        MEM_reg_stall_mem_not_ready;
  logic        resp_busy;

  data_sram_response #(.DISCARD_MAX(3)) dut (
    .clk                         (clk),
    .resetn                      (resetn),
    .data_sram_data_ok           (data_sram_data_ok),
    .data_sram_rdata             (data_sram_rdata),
    .req_accepted_EX             (req_accepted_EX),
    .EX_MEM_advance              (EX_MEM_advance),
    .MEM_WB_advance              (MEM_WB_advance),
    .flush                       (flush),
    .mem_ren_MEM                 (mem_ren_MEM),
    .mem_w_MEM                   (mem_w_MEM),
    .mem_h_MEM                   (mem_h_MEM),
    .mem_b_MEM                   (mem_b_MEM),
    .mem_hu_MEM                  (mem_hu_MEM),
    .mem_bu_MEM                  (mem_bu_MEM),
    .mem_wl_MEM                  (mem_wl_MEM),
    .mem_wr_MEM                  (mem_wr_MEM),
    .byte_offset_MEM             (byte_offset_MEM),
    .rt_old_MEM                  (rt_old_MEM),
    .load_data_MEM               (load_data_MEM),
    .MEM_reg_stall_mem_not_ready (MEM_reg_stall_mem_not_ready),
    .resp_busy                   (resp_busy)
  );

  always #5 clk = ~clk;

  // kind: 0 lw, 1 lh, 2 lb, 3 lhu, 4 lbu, 5 lwl, 6 lwr
  typedef struct {
    logic [2:0]  kind;
    logic [1:0]  off;
    logic [31:0] rt;
    logic [31:0] rdata;
  } ld_t;

  typedef struct {
    logic [31:0] rdata;
    bit          killed;
    int unsigned born;
  } bus_t;

  bus_t        busq[$];
  logic [31:0] exp_q[$];
  bit          occ, got;
  ld_t         cur;
  ld_t         dir_load;
  bit          use_dir;
  int unsigned cyc;
  bit          exp_stall, exp_busy;
  bit          run_chk, rst_chk, timeout_hit;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] ref_load(input ld_t l);
    logic [31:0] w, sb, sh;
    w  = l.rdata;
    sb = w >> (8 * l.off);
    sh = w >> (16 * l.off[1]);
    case (l.kind)
      3'd1: return {{16{sh[15]}}, sh[15:0]};
      3'd2: return {{24{sb[7]}}, sb[7:0]};
      3'd3: return {16'h0, sh[15:0]};
      3'd4: return {24'h0, sb[7:0]};
`ifdef LWLR_EN
      3'd5: return (w << (8 * (3 - l.off))) | (l.rt & ((32'h1 << (8 * (3 - l.off))) - 32'h1));
      3'd6: return (w >> (8 * l.off)) | (l.rt & ~(32'hFFFF_FFFF >> (8 * l.off)));
`endif
      default: return w;
    endcase
  endfunction

  function automatic ld_t new_load();
    ld_t l;
    l.kind  = 3'($urandom_range(0, 6));
    l.off   = 2'($urandom_range(0, 3));
    if (l.kind == 3'd1 || l.kind == 3'd3) l.off[0] = 1'b0;
    if (l.kind == 3'd0) l.off = 2'd0;
    l.rt    = $urandom;
    l.rdata = $urandom;
    return l;
  endfunction

  function automatic bit model_busy();
    foreach (busq[i]) if (busq[i].killed) return 1'b1;
    return 1'b0;
  endfunction

  task automatic quiet_inputs();
    data_sram_data_ok = 0; data_sram_rdata = '0; req_accepted_EX = 0;
    EX_MEM_advance = 0; MEM_WB_advance = 0; flush = 0;
    mem_ren_MEM = 0; mem_w_MEM = 0; mem_h_MEM = 0; mem_b_MEM = 0;
    mem_hu_MEM = 0; mem_bu_MEM = 0; mem_wl_MEM = 0; mem_wr_MEM = 0;
    byte_offset_MEM = '0; rt_old_MEM = '0;
  endtask

  // One pipeline cycle: drive inputs, set expectations, then advance the model at the edge.
  task automatic step(input bit f, input bit dok_req, input bit wb, input bit ex, input bit iss);
    bit  dok, live, have;
    ld_t nl;
    dok  = dok_req && busq.size() != 0;
    if (dok) dok = busq[0].born < cyc;
    live = dok && !busq[0].killed;
    have = got || live;

    flush             = f;
    data_sram_data_ok = dok;
    data_sram_rdata   = dok ? busq[0].rdata : $urandom;
    MEM_WB_advance    = wb;
    EX_MEM_advance    = ex;
    req_accepted_EX   = ex && iss;
    mem_ren_MEM       = occ;
    mem_w_MEM         = occ && cur.kind == 3'd0;
    mem_h_MEM         = occ && cur.kind == 3'd1;
    mem_b_MEM         = occ && cur.kind == 3'd2;
    mem_hu_MEM        = occ && cur.kind == 3'd3;
    mem_bu_MEM        = occ && cur.kind == 3'd4;
    mem_wl_MEM        = occ && cur.kind == 3'd5;
    mem_wr_MEM        = occ && cur.kind == 3'd6;
    byte_offset_MEM   = occ ? cur.off : 2'($urandom);
    rt_old_MEM        = occ ? cur.rt : $urandom;
    exp_stall         = occ && !got && !live;
    exp_busy          = model_busy();

    @(posedge clk);
    if (dok) begin
      void'(busq.pop_front());
      if (live) got = 1'b1;
    end
    if (f) begin
      foreach (busq[i]) busq[i].killed = 1'b1;
      if (occ && exp_q.size() != 0) void'(exp_q.pop_back());
      occ = 1'b0;
      got = 1'b0;
    end else if (occ && wb && have) begin
      occ = 1'b0;
      got = 1'b0;
    end
    if (ex && iss) begin
      if (use_dir) begin
        nl      = dir_load;
        use_dir = 1'b0;
      end else begin
        nl = new_load();
      end
      busq.push_back('{rdata: nl.rdata, killed: f, born: cyc});
      if (!f) begin
        occ = 1'b1;
        got = 1'b0;
        cur = nl;
        exp_q.push_back(ref_load(nl));
      end
    end
    cyc++;
    #1;
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      bit f, dok, wb, ex, iss, have;
      f    = ($urandom_range(0, 15) == 0);
      dok  = 1'b0;
      have = got;
      if (busq.size() != 0) begin
        dok = (busq[0].born < cyc) && ($urandom_range(0, 2) != 0);
        if (dok && !busq[0].killed) have = 1'b1;
      end
      wb  = occ ? (have && $urandom_range(0, 1) == 1) : ($urandom_range(0, 1) == 1);
      ex  = (!occ || (wb && have) || f) && ($urandom_range(0, 1) == 1);
      iss = !model_busy() && ($urandom_range(0, 3) != 0);
      step(f, dok, wb, ex, iss);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busq.size() != 0 || occ) && k < 50) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      k++;
    end
    if (busq.size() != 0 || occ) begin
      timeout_hit = 1'b1;
      @(negedge clk);
      #1 timeout_hit = 1'b0;
    end
  endtask

  task automatic set_dir(input logic [2:0] kind, input logic [1:0] off,
                         input logic [31:0] rt, input logic [31:0] rdata);
    dir_load = '{kind: kind, off: off, rt: rt, rdata: rdata};
    use_dir  = 1'b1;
  endtask

  always @(negedge clk) begin
    if (timeout_hit) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses still outstanding, occupied=%0b, required none", busq.size(), occ);
    end
    if (rst_chk) begin
      checks++;
      if (MEM_reg_stall_mem_not_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall: got %b, expected 0", MEM_reg_stall_mem_not_ready);
      end
      checks++;
      if (resp_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy: got %b, expected 0", resp_busy);
      end
      checks++;
      if (load_data_MEM !== 32'h0) begin
        errors++;
        $display("FAIL reset_load_data: got %h, expected 00000000", load_data_MEM);
      end
    end
    if (run_chk) begin
      checks++;
      if (MEM_reg_stall_mem_not_ready !== exp_stall) begin
        errors++;
        $display("FAIL stall cyc=%0d: got %b, expected %b", cyc, MEM_reg_stall_mem_not_ready, exp_stall);
      end
      checks++;
      if (resp_busy !== exp_busy) begin
        errors++;
        $display("FAIL resp_busy cyc=%0d: got %b, expected %b", cyc, resp_busy, exp_busy);
      end
      if (occ && !flush && MEM_reg_stall_mem_not_ready === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL load_data cyc=%0d: got %h, expected no result presented", cyc, load_data_MEM);
        end else begin
          if (load_data_MEM !== exp_q[0]) begin
            errors++;
            $display("FAIL load_data cyc=%0d kind=%0d off=%0d: got %h, expected %h",
                     cyc, cur.kind, cur.off, load_data_MEM, exp_q[0]);
          end
          if (MEM_WB_advance) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    quiet_inputs();
    occ = 0; got = 0; use_dir = 0; cyc = 0;
    run_chk = 0; rst_chk = 0; timeout_hit = 0;
    exp_stall = 0; exp_busy = 0;
    cur = '{kind: '0, off: '0, rt: '0, rdata: '0};
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rst_chk = 1'b1;
    @(negedge clk);
    #1 rst_chk = 1'b0;
    run_chk = 1'b1;

    // lb offset 2 after three stalled cycles
    set_dir(3'd2, 2'd2, 32'h0, 32'h1280_3456);
    step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);

    // lhu offset 2 held across stalled WB cycles while the bus data changes
    set_dir(3'd3, 2'd2, 32'h0, 32'hBEEF_0000);
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    // flush in WAIT, new lw next cycle: first response dropped
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    set_dir(3'd0, 2'd0, 32'h0, 32'hCAFE_F00D);
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);

    // flush while a new request enters MEM: two responses dropped
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);

`ifdef LWLR_EN
    set_dir(3'd5, 2'd1, 32'h1122_3344, 32'hAABB_CCDD);
    step(0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0);
    set_dir(3'd6, 2'd1, 32'h1122_3344, 32'hAABB_CCDD);
    step(0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0);
`endif

    random_phase(3000);
    drain();

    // reset while in WAIT with one pending discard
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    run_chk = 1'b0;
    quiet_inputs();
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    busq.delete();
    exp_q.delete();
    occ = 0;
    got = 0;
    rst_chk = 1'b1;
    @(negedge clk);
    #1 rst_chk = 1'b0;
    run_chk = 1'b1;

    random_phase(500);
    drain();
    run_chk = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
